// File: rtl/obj_draw_sequencer.sv
// Per-frame object sequencer: erases last frame's rectangles, then draws every live
// object, feeding the rectangle draw stage one slot at a time.
module obj_draw_sequencer #(
    parameter int         NUM_OBJ   = 8,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_tick,
    input  logic [8*NUM_OBJ-1:0] obj_x,
    input  logic [7*NUM_OBJ-1:0] obj_y,
    input  logic [5*NUM_OBJ-1:0] obj_w,
    input  logic [5*NUM_OBJ-1:0] obj_h,
    input  logic [3*NUM_OBJ-1:0] obj_c,
    input  logic [NUM_OBJ-1:0]   obj_valid,
    input  logic                 draw_done,
    output logic [7:0]           x_in,
    output logic [6:0]           y_in,
    output logic [4:0]           width,
    output logic [4:0]           height,
    output logic [2:0]           c_in,
    output logic                 enable_load,
    output logic                 enable_draw,
    output logic                 plot,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 overrun,
    output logic [3:0]           dbg_state_o
);

    // Handshake: enable_load pulses one cycle to present a rectangle, enable_draw then
    // holds until draw_done is seen, and drops for one cycle so the stage clears done.

    localparam int IW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_OBJ - 1);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        E_SEL  = 4'd1,
        E_LOAD = 4'd2,
        E_DRAW = 4'd3,
        E_GAP  = 4'd4,
        D_SEL  = 4'd5,
        D_LOAD = 4'd6,
        D_DRAW = 4'd7,
        D_GAP  = 4'd8,
        FIN    = 4'd9
    } state_t;

    state_t              state_q;
    logic [IW-1:0]       idx_q;

    logic [7:0]          cur_x_q  [NUM_OBJ];
    logic [6:0]          cur_y_q  [NUM_OBJ];
    logic [4:0]          cur_w_q  [NUM_OBJ];
    logic [4:0]          cur_h_q  [NUM_OBJ];
    logic [2:0]          cur_c_q  [NUM_OBJ];
    logic [NUM_OBJ-1:0]  cur_valid_q;

    logic [7:0]          prev_x_q [NUM_OBJ];
    logic [6:0]          prev_y_q [NUM_OBJ];
    logic [4:0]          prev_w_q [NUM_OBJ];
    logic [4:0]          prev_h_q [NUM_OBJ];
    logic [NUM_OBJ-1:0]  prev_valid_q;

    logic [NUM_OBJ-1:0]  obj_live;
    logic [NUM_OBJ-1:0]  scan_vec;
    logic                scan_found;
    logic [IW-1:0]       scan_idx;

    always_comb begin
        for (int i = 0; i < NUM_OBJ; i++) begin
            obj_live[i] = obj_valid[i] & (|obj_w[5*i +: 5]) & (|obj_h[5*i +: 5]);
        end
    end

    // Lowest set slot at or above idx_q; the erase pass walks last frame's slots.
    always_comb begin
        scan_vec   = (state_q == D_SEL) ? cur_valid_q : prev_valid_q;
        scan_found = 1'b0;
        scan_idx   = idx_q;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (scan_vec[i] && (i >= int'(idx_q))) begin
                scan_found = 1'b1;
                scan_idx   = IW'(i);
            end
        end
    end

    assign busy        = (state_q != IDLE);
    assign plot        = enable_draw & ~draw_done;
    assign overrun     = frame_tick & busy;
    assign dbg_state_o = state_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cur_valid_q  <= '0;
            prev_valid_q <= '0;
            for (int i = 0; i < NUM_OBJ; i++) begin
                cur_x_q[i]  <= '0;
                cur_y_q[i]  <= '0;
                cur_w_q[i]  <= '0;
                cur_h_q[i]  <= '0;
                cur_c_q[i]  <= '0;
                prev_x_q[i] <= '0;
                prev_y_q[i] <= '0;
                prev_w_q[i] <= '0;
                prev_h_q[i] <= '0;
            end
            x_in        <= '0;
            y_in        <= '0;
            width       <= '0;
            height      <= '0;
            c_in        <= '0;
            enable_load <= 1'b0;
            enable_draw <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (frame_tick) begin
                        for (int i = 0; i < NUM_OBJ; i++) begin
                            cur_x_q[i] <= obj_x[8*i +: 8];
                            cur_y_q[i] <= obj_y[7*i +: 7];
                            cur_w_q[i] <= obj_w[5*i +: 5];
                            cur_h_q[i] <= obj_h[5*i +: 5];
                            cur_c_q[i] <= obj_c[3*i +: 3];
                        end
                        cur_valid_q <= obj_live;
                        idx_q       <= '0;
                        state_q     <= E_SEL;
                    end
                end
                E_SEL: begin
                    if (scan_found) begin
                        idx_q       <= scan_idx;
                        x_in        <= prev_x_q[scan_idx];
                        y_in        <= prev_y_q[scan_idx];
                        width       <= prev_w_q[scan_idx];
                        height      <= prev_h_q[scan_idx];
                        c_in        <= BG_COLOUR;
                        enable_load <= 1'b1;
                        state_q     <= E_LOAD;
                    end else begin
                        idx_q   <= '0;
                        state_q <= D_SEL;
                    end
                end
                E_LOAD: begin
                    enable_load <= 1'b0;
                    enable_draw <= 1'b1;
                    state_q     <= E_DRAW;
                end
                E_DRAW: begin
                    if (draw_done) begin
                        enable_draw <= 1'b0;
                        state_q     <= E_GAP;
                    end
                end
                E_GAP: begin
                    if (idx_q == LAST_IDX) begin
                        idx_q   <= '0;
                        state_q <= D_SEL;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= E_SEL;
                    end
                end
                D_SEL: begin
                    if (scan_found) begin
                        idx_q       <= scan_idx;
                        x_in        <= cur_x_q[scan_idx];
                        y_in        <= cur_y_q[scan_idx];
                        width       <= cur_w_q[scan_idx];
                        height      <= cur_h_q[scan_idx];
                        c_in        <= cur_c_q[scan_idx];
                        enable_load <= 1'b1;
                        state_q     <= D_LOAD;
                    end else begin
                        frame_done <= 1'b1;
                        state_q    <= FIN;
                    end
                end
                D_LOAD: begin
                    enable_load <= 1'b0;
                    enable_draw <= 1'b1;
                    state_q     <= D_DRAW;
                end
                D_DRAW: begin
                    if (draw_done) begin
                        enable_draw <= 1'b0;
                        state_q     <= D_GAP;
                    end
                end
                D_GAP: begin
                    if (idx_q == LAST_IDX) begin
                        frame_done <= 1'b1;
                        state_q    <= FIN;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= D_SEL;
                    end
                end
                FIN: begin
                    // What was just drawn becomes next frame's erase list.
                    prev_x_q     <= cur_x_q;
                    prev_y_q     <= cur_y_q;
                    prev_w_q     <= cur_w_q;
                    prev_h_q     <= cur_h_q;
                    prev_valid_q <= cur_valid_q;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_obj_draw_sequencer.sv
// Bench for obj_draw_sequencer: a rectangle draw-stage model turns plot strobes into
// pixels, which are scored against a per-frame erase/draw reference list.
module tb_obj_draw_sequencer;

    localparam int         N  = 8;
    localparam logic [2:0] BG = 3'b000;

    logic           clk        = 1'b0;
    logic           reset      = 1'b0;
    logic           frame_tick = 1'b0;
    logic [8*N-1:0] obj_x      = '0;
    logic [7*N-1:0] obj_y      = '0;
    logic [5*N-1:0] obj_w      = '0;
    logic [5*N-1:0] obj_h      = '0;
    logic [3*N-1:0] obj_c      = '0;
    logic [N-1:0]   obj_valid  = '0;
    logic           draw_done  = 1'b0;
    logic [7:0]     x_in;
    logic [6:0]     y_in;
    logic [4:0]     width;
    logic [4:0]     height;
    logic [2:0]     c_in;
    logic           enable_load;
    logic           enable_draw;
    logic           plot;
    logic           busy;
    logic           frame_done;
    logic           overrun;
    logic [3:0]     dbg_state;

    always #5 clk = ~clk;

    obj_draw_sequencer #(.NUM_OBJ(N), .BG_COLOUR(BG)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .obj_x       (obj_x),
        .obj_y       (obj_y),
        .obj_w       (obj_w),
        .obj_h       (obj_h),
        .obj_c       (obj_c),
        .obj_valid   (obj_valid),
        .draw_done   (draw_done),
        .x_in        (x_in),
        .y_in        (y_in),
        .width       (width),
        .height      (height),
        .c_in        (c_in),
        .enable_load (enable_load),
        .enable_draw (enable_draw),
        .plot        (plot),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun     (overrun),
        .dbg_state_o (dbg_state)
    );

    int          n_tests  = 0;
    int          n_fail   = 0;
    int          fd_cnt   = 0;
    int          plot_cnt = 0;
    logic [17:0] exp_q[$];
    logic [7:0]  load_q[$];
    logic [17:0] pix;

    // Stimulus slots, the frame being drawn, and what the screen held after the last frame.
    logic [7:0] s_x[N];
    logic [6:0] s_y[N];
    int         s_w[N];
    int         s_h[N];
    logic [2:0] s_c[N];
    bit         s_v[N];
    logic [7:0] n_x[N];
    logic [6:0] n_y[N];
    int         n_w[N];
    int         n_h[N];
    bit         n_live[N];
    logic [7:0] p_x[N];
    logic [6:0] p_y[N];
    int         p_w[N];
    int         p_h[N];
    bit         p_live[N];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Rectangle draw stage: latches the corner on load, walks w*h pixels row-major,
    // raises done after the last one and clears it once enable_draw drops.
    int         ds_cnt = 0;
    logic [7:0] ds_x   = '0;
    logic [6:0] ds_y   = '0;

    always @(posedge clk) begin
        if (!reset) begin
            ds_cnt    <= 0;
            draw_done <= 1'b0;
        end else if (enable_load) begin
            ds_cnt    <= 0;
            draw_done <= 1'b0;
            ds_x      <= x_in;
            ds_y      <= y_in;
        end else if (enable_draw) begin
            if (!draw_done) begin
                if (ds_cnt >= int'(width) * int'(height) - 1) draw_done <= 1'b1;
                else ds_cnt <= ds_cnt + 1;
            end
        end else begin
            draw_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
        if (enable_load) load_q.push_back(x_in);
        if (enable_load || enable_draw) chk("load_draw_exclusive", {31'd0, enable_load & enable_draw}, 0);
        if (plot) begin
            plot_cnt++;
            chk("plot_width_nonzero", {31'd0, width != 0}, 1);
            chk("pixel_expected", {31'd0, exp_q.size() != 0}, 1);
            if (width != 0 && exp_q.size() != 0) begin
                pix = {8'(int'(ds_x) + ds_cnt % int'(width)), 7'(int'(ds_y) + ds_cnt / int'(width)), c_in};
                chk("pixel", {14'd0, pix}, {14'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic apply_inputs();
        for (int i = 0; i < N; i++) begin
            obj_x[8*i +: 8] = s_x[i];
            obj_y[7*i +: 7] = s_y[i];
            obj_w[5*i +: 5] = 5'(s_w[i]);
            obj_h[5*i +: 5] = 5'(s_h[i]);
            obj_c[3*i +: 3] = s_c[i];
            obj_valid[i]    = s_v[i];
        end
    endtask

    task automatic clear_slots();
        for (int i = 0; i < N; i++) begin
            s_x[i] = 8'($urandom);
            s_y[i] = 7'($urandom);
            s_w[i] = 1;
            s_h[i] = 1;
            s_c[i] = 3'($urandom);
            s_v[i] = 1'b0;
        end
    endtask

    task automatic set_slot(input int i, input int x, input int y, input int w, input int h, input int c);
        s_x[i] = 8'(x);
        s_y[i] = 7'(y);
        s_w[i] = w;
        s_h[i] = h;
        s_c[i] = 3'(c);
        s_v[i] = 1'b1;
    endtask

    task automatic push_rect(input logic [7:0] x, input logic [6:0] y, input int w, input int h,
                             input logic [2:0] c);
        for (int r = 0; r < h; r++) begin
            for (int q = 0; q < w; q++) begin
                exp_q.push_back({8'(int'(x) + q), 7'(int'(y) + r), c});
            end
        end
    endtask

    // Builds the frame's expected pixels, pulses the tick, then scrambles the inputs.
    task automatic start_frame();
        apply_inputs();
        fd_cnt   = 0;
        plot_cnt = 0;
        load_q.delete();
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            if (p_live[i]) push_rect(p_x[i], p_y[i], p_w[i], p_h[i], BG);
        end
        for (int i = 0; i < N; i++) begin
            n_live[i] = s_v[i] && s_w[i] != 0 && s_h[i] != 0;
            n_x[i] = s_x[i];
            n_y[i] = s_y[i];
            n_w[i] = s_w[i];
            n_h[i] = s_h[i];
            if (n_live[i]) push_rect(s_x[i], s_y[i], s_w[i], s_h[i], s_c[i]);
        end
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        for (int i = 0; i < N; i++) begin
            s_x[i] = 8'($urandom);
            s_y[i] = 7'($urandom);
            s_w[i] = $urandom_range(0, 31);
            s_h[i] = $urandom_range(0, 31);
            s_c[i] = 3'($urandom);
            s_v[i] = 1'($urandom_range(0, 1));
        end
        apply_inputs();
    endtask

    task automatic finish_frame(input string tag);
        int guard = 0;
        while (fd_cnt == 0 && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_done_seen"}, {31'd0, fd_cnt != 0}, 1);
        repeat (4) @(negedge clk);
        chk({tag, "_done_once"}, fd_cnt, 1);
        chk({tag, "_pixels_left"}, exp_q.size(), 0);
        chk({tag, "_idle"}, {31'd0, busy}, 0);
        for (int i = 0; i < N; i++) begin
            p_x[i]    = n_x[i];
            p_y[i]    = n_y[i];
            p_w[i]    = n_w[i];
            p_h[i]    = n_h[i];
            p_live[i] = n_live[i];
        end
        exp_q.delete();
    endtask

    task automatic wait_draw(input string tag, input bit need_colour);
        int guard = 0;
        while (!(enable_draw && (!need_colour || c_in != BG)) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_draw_seen"}, {31'd0, guard < 2000}, 1);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N; i++) p_live[i] = 1'b0;
        clear_slots();
        apply_inputs();
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_plot", {31'd0, plot}, 0);
        chk("rst_frame_done", {31'd0, frame_done}, 0);
        chk("rst_enables", {30'd0, enable_load, enable_draw}, 0);
        chk("rst_coords", {9'd0, x_in, y_in, width, height, c_in}, 0);
        chk("rst_overrun", {31'd0, overrun}, 0);
        reset = 1'b1;
        @(negedge clk);

        // Single 2x2 object, nothing to erase yet.
        clear_slots();
        set_slot(0, 10, 20, 2, 2, 3'b100);
        start_frame();
        @(negedge clk);
        chk("t1_no_load_yet", {31'd0, enable_load}, 0);
        @(negedge clk);
        chk("t1_load", {31'd0, enable_load}, 1);
        chk("t1_load_fields", {9'd0, x_in, y_in, width, height, c_in},
            {9'd0, 8'd10, 7'd20, 5'd2, 5'd2, 3'b100});
        finish_frame("t1");
        chk("t1_plot_count", plot_cnt, 4);

        // Moved object: erase at old spot first, one cycle after the tick.
        clear_slots();
        set_slot(0, 12, 20, 2, 2, 3'b100);
        start_frame();
        @(negedge clk);
        chk("t2_erase_load", {31'd0, enable_load}, 1);
        chk("t2_erase_fields", {13'd0, x_in, y_in, c_in}, {13'd0, 8'd10, 7'd20, BG});
        finish_frame("t2");
        chk("t2_plot_count", plot_cnt, 8);

        // Zero-width slot is skipped; scan is ascending.
        clear_slots();
        set_slot(1, 40, 30, 3, 2, 3'b001);
        set_slot(4, 70, 30, 0, 3, 3'b010);
        set_slot(7, 90, 60, 2, 2, 3'b011);
        start_frame();
        finish_frame("t3");
        chk("t3_load_count", load_q.size(), 3);
        if (load_q.size() == 3) begin
            chk("t3_load0", {24'd0, load_q[0]}, 12);
            chk("t3_load1", {24'd0, load_q[1]}, 40);
            chk("t3_load2", {24'd0, load_q[2]}, 90);
        end
        chk("t3_plot_count", plot_cnt, 14);

        // Tick while busy only flags overrun.
        clear_slots();
        set_slot(2, 30, 40, 3, 3, 3'b010);
        set_slot(5, 60, 10, 2, 4, 3'b110);
        start_frame();
        wait_draw("t4", 1'b0);
        frame_tick = 1'b1;
        #1;
        chk("t4_overrun_high", {31'd0, overrun}, 1);
        @(negedge clk);
        frame_tick = 1'b0;
        #1;
        chk("t4_overrun_low", {31'd0, overrun}, 0);
        finish_frame("t4");

        // Reset during the draw pass, then a frame that must not erase.
        clear_slots();
        set_slot(3, 50, 50, 4, 4, 3'b101);
        start_frame();
        wait_draw("t5", 1'b1);
        reset = 1'b0;
        @(negedge clk);
        chk("t5_busy", {31'd0, busy}, 0);
        chk("t5_enables", {30'd0, enable_load, enable_draw}, 0);
        chk("t5_plot", {31'd0, plot}, 0);
        chk("t5_coords", {9'd0, x_in, y_in, width, height, c_in}, 0);
        reset = 1'b1;
        exp_q.delete();
        for (int i = 0; i < N; i++) p_live[i] = 1'b0;
        clear_slots();
        set_slot(6, 5, 5, 2, 3, 3'b111);
        start_frame();
        finish_frame("t5_after");
        chk("t5_single_load", load_q.size(), 1);
        chk("t5_plot_count", plot_cnt, 6);

        // Erase what is left, then an empty frame.
        clear_slots();
        start_frame();
        finish_frame("t6_clear");
        clear_slots();
        start_frame();
        @(negedge clk);
        chk("t6_done_early", {31'd0, frame_done}, 0);
        @(negedge clk);
        chk("t6_done_at_3", {31'd0, frame_done}, 1);
        finish_frame("t6");
        chk("t6_no_plot", plot_cnt, 0);

        for (int f = 0; f < 20; f++) begin
            clear_slots();
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) != 0)
                    set_slot(i, $urandom_range(0, 255), $urandom_range(0, 127),
                             $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 7));
            end
            start_frame();
            finish_frame("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
